pulse_meas: RTL and testbench

PULSE_MEAS -- requirements
Module: pulse_meas

---
 rtl/pulse_meas.sv | 177 +++++++++++++++++
 tb/tb_pulse_meas.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meas.sv
//==============================================================================
// Module      : pulse_meas
// Description : Measures period and high time of a slow asynchronous waveform
//               in clk cycles. Define PULSE_MEAS_DUTY_EN to enable high-time.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pulse_meas #(
  parameter int CNT_W   = 35,
  parameter int TIMEOUT = 60000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2, r_dly, r_rise;
  logic             w_rise;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_at_limit;

`ifdef PULSE_MEAS_DUTY_EN
  logic             r_fall, w_fall;
  logic [CNT_W-1:0] r_hi_lat, w_hi_lat_nxt;
  logic [CNT_W-1:0] r_high, w_high_nxt;
  assign w_fall = ~r_sync2 & r_dly;
`endif

  assign w_rise     = r_sync2 & ~r_dly;
  assign w_at_limit = (r_cnt == C_TIMEOUT);
  // Saturate so an edge accepted exactly at the limit never pushes cnt past it
  assign w_cnt_inc  = w_at_limit ? r_cnt : r_cnt + C_ONE;

  // Edge detects are registered once more; rise and fall share the delay,
  // so it cancels out of both period and high time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
      r_rise  <= 1'b0;
`ifdef PULSE_MEAS_DUTY_EN
      r_fall  <= 1'b0;
`endif
    end else begin
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
      r_rise  <= w_rise;
`ifdef PULSE_MEAS_DUTY_EN
      r_fall  <= w_fall;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;
`ifdef PULSE_MEAS_DUTY_EN
    w_hi_lat_nxt  = r_hi_lat;
    w_high_nxt    = r_high;
`endif

    case (r_state)
      S_IDLE: begin
        if (r_rise) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = C_ONE;
        end
      end
`ifdef PULSE_MEAS_DUTY_EN
      S_HIGH: begin
        if (r_fall) begin
          w_state_nxt  = S_LOW;
          w_hi_lat_nxt = r_cnt;
          w_cnt_nxt    = w_cnt_inc;
        end else if (w_at_limit) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
`endif
      default: begin
        // Without duty measurement HIGH behaves exactly like LOW
        if (r_rise) begin
          w_state_nxt   = S_HIGH;
          w_period_nxt  = r_cnt;
          w_valid_nxt   = 1'b1;
          w_timeout_nxt = 1'b0;
          w_cnt_nxt     = C_ONE;
`ifdef PULSE_MEAS_DUTY_EN
          w_high_nxt    = r_hi_lat;
`endif
        end else if (w_at_limit) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
    endcase

    if (clear) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_period_nxt  = '0;
      w_valid_nxt   = 1'b0;
      w_timeout_nxt = 1'b0;
`ifdef PULSE_MEAS_DUTY_EN
      w_hi_lat_nxt  = '0;
      w_high_nxt    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
`ifdef PULSE_MEAS_DUTY_EN
      r_hi_lat  <= '0;
      r_high    <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
`ifdef PULSE_MEAS_DUTY_EN
      r_hi_lat  <= w_hi_lat_nxt;
      r_high    <= w_high_nxt;
`endif
    end
  end

  assign period     = r_period;
  assign meas_valid = r_valid;
  assign timeout    = r_timeout;
`ifdef PULSE_MEAS_DUTY_EN
  assign high_time  = r_high;
`else
  assign high_time  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_meas.sv
// Self-checking bench for pulse_meas (CNT_W=35, TIMEOUT=100).
`default_nettype none

module tb_pulse_meas;

  localparam int CW = 35;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse_in = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] period, high_time;
  logic          meas_valid, timeout;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    longint p;
    longint h;
    logic   to;
  } obs_t;
  obs_t obs_q[$];

  typedef struct {
    int     h;
    int     l;
    int     n;
    int     strobes;
    longint per;
    longint hi;
  } vec_t;

  pulse_meas #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .clear      (clear),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rst && meas_valid) obs_q.push_back('{longint'(period), longint'(high_time), timeout});
  end

  function automatic longint exp_hi(input longint h);
`ifdef PULSE_MEAS_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic hold(input logic lvl, input int n);
    pulse_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    hold(1'b0, 4);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, longint'(period), 0);
    chk({tag, "_high"}, longint'(high_time), 0);
    chk({tag, "_valid"}, longint'(meas_valid), 0);
    chk({tag, "_timeout"}, longint'(timeout), 0);
  endtask

  vec_t vecs[7];
  int   hs[30], ls[30];
  obs_t exp_q[$];

  initial begin
    vecs[0] = '{8, 12, 4, 3, 20, 8};
    vecs[1] = '{2, 2, 5, 4, 4, 2};
    vecs[2] = '{3, 7, 3, 2, 10, 3};
    vecs[3] = '{50, 50, 3, 2, 100, 50};   // edge exactly at the limit
    vecs[4] = '{2, 98, 3, 2, 100, 2};
    vecs[5] = '{60, 41, 3, 0, 0, 0};      // one cycle beyond the limit
    vecs[6] = '{100, 2, 3, 0, 0, 0};

    // Reset state
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk_zero("reset");

    // Table-driven square waves
    foreach (vecs[k]) begin
      do_clear();
      obs_q.delete();
      for (int i = 0; i < vecs[k].n; i++) begin
        hold(1'b1, vecs[k].h);
        hold(1'b0, vecs[k].l);
      end
      hold(1'b0, 6);
      chk($sformatf("vec%0d_strobes", k), obs_q.size(), vecs[k].strobes);
      if (obs_q.size() > 0) begin
        chk($sformatf("vec%0d_period", k), obs_q[$].p, vecs[k].per);
        chk($sformatf("vec%0d_high", k), obs_q[$].h, exp_hi(vecs[k].hi));
      end
    end

    // Exact strobe latency, then stuck-high timeout at cnt == TIMEOUT
    do_clear();
    hold(1'b1, 8);
    hold(1'b0, 12);
    pulse_in = 1'b1;
    @(posedge clk);              // first edge sampling high
    repeat (2) @(posedge clk);
    #1 chk("lat_early", longint'(meas_valid), 0);
    @(posedge clk);
    #1 chk("lat_valid", longint'(meas_valid), 1);
    chk("lat_period", longint'(period), 20);
    chk("lat_high", longint'(high_time), exp_hi(8));
    @(posedge clk);
    #1 chk("lat_one_cycle", longint'(meas_valid), 0);
    repeat (98) @(posedge clk);
    #1 chk("to_before", longint'(timeout), 0);
    @(posedge clk);
    #1 chk("to_assert", longint'(timeout), 1);
    chk("to_period_kept", longint'(period), 20);
    chk("to_high_kept", longint'(high_time), exp_hi(8));

    // Recovery after timeout: first rise arms, next full period clears timeout
    @(negedge clk);
    obs_q.delete();
    hold(1'b0, 12);
    hold(1'b1, 8);
    hold(1'b0, 12);
    chk("to_held", longint'(timeout), 1);
    hold(1'b1, 4);
    chk("rec_strobes", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("rec_period", obs_q[0].p, 20);
      chk("rec_to_at_strobe", longint'(obs_q[0].to), 0);
    end
    chk("rec_timeout", longint'(timeout), 0);

    // Clear mid-LOW
    hold(1'b0, 6);
    clear = 1'b1;
    @(posedge clk);
    #1 chk_zero("clear");
    @(negedge clk);
    clear = 1'b0;
    obs_q.delete();
    hold(1'b0, 6);
    hold(1'b1, 8);
    hold(1'b0, 12);
    hold(1'b1, 8);
    hold(1'b0, 6);
    chk("clr_strobes", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("clr_period", obs_q[0].p, 20);
      chk("clr_high", obs_q[0].h, exp_hi(8));
    end

    // Asynchronous reset mid-HIGH
    hold(1'b0, 6);
    hold(1'b1, 6);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_zero("rst_mid");
    @(posedge clk);
    #3 rst = 1'b1;
    obs_q.delete();
    hold(1'b1, 3);
    hold(1'b0, 12);
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 8);
      hold(1'b0, 12);
    end
    hold(1'b0, 4);
    chk("rst_strobes", obs_q.size(), 3);
    if (obs_q.size() > 0) begin
      chk("rst_period", obs_q[$].p, 20);
      chk("rst_high", obs_q[$].h, exp_hi(8));
    end

    // Random waveforms against a segment-level model: every rise restarts
    // the count; a rise yields a strobe only if the preceding high+low span
    // fit within TIMEOUT.
    do_clear();
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      hs[i] = int'($urandom_range(70, 2));
      ls[i] = int'($urandom_range(70, 2));
      if (i > 0 && hs[i-1] + ls[i-1] <= TO)
        exp_q.push_back('{longint'(hs[i-1] + ls[i-1]), exp_hi(hs[i-1]), 1'b0});
    end
    for (int i = 0; i < 30; i++) begin
      hold(1'b1, hs[i]);
      hold(1'b0, ls[i]);
    end
    hold(1'b0, 110);
    chk("rand_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("rand%0d_period", i), obs_q[i].p, exp_q[i].p);
      chk($sformatf("rand%0d_high", i), obs_q[i].h, exp_q[i].h);
      chk($sformatf("rand%0d_to", i), longint'(obs_q[i].to), 0);
    end
    chk("rand_final_timeout", longint'(timeout), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
